// File: rtl/cic_tile.sv
// Per-channel CIC slave tile: four bus registers, a free-running period counter
// driving PWM and a wrap pulse, and a 16-bit daisy-chain shift register for broadcast duty loads.
module cic_tile (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        io_cs_i,
    input  logic        io_we_i,
    input  logic [1:0]  io_adr_i,
    input  logic [15:0] io_dat_i,
    output logic [15:0] io_dat_o,
    input  logic        io_shift_i,
    input  logic        io_dsi_i,
    output logic        io_dsi_o,
    input  logic        io_sync_i,
    output logic        io_pwm_o,
    output logic        io_wrap_o
);

    logic        en;
    logic        oneshot;
    logic        inv;
    logic        sync_en;
    logic        wrap_flag;
    logic [15:0] period;
    logic [15:0] duty_sh;
    logic [15:0] duty_act;
    logic [15:0] cnt;
    logic [15:0] sr;

    logic wr;
    logic wr_ctrl;
    logic wr_period;
    logic wr_duty;
    logic sync_hit;
    logic at_period;
    logic wrap_hit;
    logic raw;

    assign wr        = io_cs_i & io_we_i;
    assign wr_ctrl   = wr & (io_adr_i == 2'd0);
    assign wr_period = wr & (io_adr_i == 2'd1);
    assign wr_duty   = wr & (io_adr_i == 2'd2);

    // A sync strobe restarts the period and suppresses any wrap in the same cycle.
    assign sync_hit  = io_sync_i & sync_en;
    assign at_period = (cnt == period);
    assign wrap_hit  = en & at_period & ~sync_hit;
    assign raw       = en & (cnt < duty_act);

    // Control register; a bus write wins over the oneshot self-clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en        <= 1'b0;
            oneshot   <= 1'b0;
            inv       <= 1'b0;
            sync_en   <= 1'b0;
            wrap_flag <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en      <= io_dat_i[0];
                oneshot <= io_dat_i[1];
                inv     <= io_dat_i[2];
                sync_en <= io_dat_i[3];
            end else if (wrap_hit && oneshot) begin
                en <= 1'b0;
            end
            if (wrap_hit) begin
                wrap_flag <= 1'b1;
            end else if (wr_ctrl && io_dat_i[15]) begin
                wrap_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            period   <= 16'hFFFF;
            duty_sh  <= 16'h0000;
            duty_act <= 16'h0000;
            cnt      <= 16'h0000;
        end else begin
            if (wr_period) begin
                period <= io_dat_i;
            end
            if (wr_duty) begin
                duty_sh <= io_dat_i;
            end else if (sync_hit) begin
                duty_sh <= sr;
            end
            // The active duty only changes at period boundaries, so a running waveform never glitches.
            if (sync_hit) begin
                duty_act <= sr;
            end else if (wrap_hit || !en) begin
                duty_act <= duty_sh;
            end
            if (sync_hit || !en || at_period) begin
                cnt <= 16'h0000;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sr        <= 16'h0000;
            io_pwm_o  <= 1'b0;
            io_wrap_o <= 1'b0;
        end else begin
            if (io_shift_i) begin
                sr <= {sr[14:0], io_dsi_i};
            end
            io_pwm_o  <= raw ^ inv;
            io_wrap_o <= wrap_hit;
        end
    end

    assign io_dsi_o = sr[15];

    // Deselected tiles drive zero so the controller can OR all read buses together.
    always_comb begin
        io_dat_o = 16'h0000;
        if (io_cs_i) begin
            case (io_adr_i)
                2'd0:    io_dat_o = {wrap_flag, 11'd0, sync_en, inv, oneshot, en};
                2'd1:    io_dat_o = period;
                2'd2:    io_dat_o = duty_sh;
                default: io_dat_o = cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_tile.sv
// Directed bench for cic_tile: two chained tiles, expected values queued as stimulus is driven
// and popped when the tile output is sampled.
module tb_cic_tile;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs0, cs1, we, shift, dsi_in, sync;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [15:0] dat_o0, dat_o1;
    logic        dsi_mid, dsi_o1;
    logic        pwm0, pwm1, wrap0, wrap1;

    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    cic_tile u_tile0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .io_cs_i(cs0), .io_we_i(we), .io_adr_i(adr),
        .io_dat_i(dat), .io_dat_o(dat_o0), .io_shift_i(shift), .io_dsi_i(dsi_in),
        .io_dsi_o(dsi_mid), .io_sync_i(sync), .io_pwm_o(pwm0), .io_wrap_o(wrap0)
    );

    cic_tile u_tile1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .io_cs_i(cs1), .io_we_i(we), .io_adr_i(adr),
        .io_dat_i(dat), .io_dat_o(dat_o1), .io_shift_i(shift), .io_dsi_i(dsi_mid),
        .io_dsi_o(dsi_o1), .io_sync_i(sync), .io_pwm_o(pwm1), .io_wrap_o(wrap1)
    );

    task automatic check_pop(input string tag, input logic [15:0] obs);
        logic [15:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h with no expected value queued", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic sel, input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        cs0 = ~sel; cs1 = sel; we = 1'b1; adr = a; dat = d;
        @(posedge clk);
        #1;
        cs0 = 1'b0; cs1 = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic sel, input logic [1:0] a, input logic [15:0] want,
                            input string tag);
        @(negedge clk);
        cs0 = ~sel; cs1 = sel; we = 1'b0; adr = a;
        exp_q.push_back(want);
        #1;
        check_pop(tag, sel ? dat_o1 : dat_o0);
        cs0 = 1'b0; cs1 = 1'b0;
    endtask

    // Leaves the caller at the falling edge of the cycle in which io_wrap_o is high.
    task automatic wait_wrap(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wrap0 && n < 200);
        exp_q.push_back(16'h0001);
        check_pop(tag, {15'd0, wrap0});
    endtask

    // Cycle i after a wrap shows pwm for counter value (i-1) mod (period+1); optionally writes
    // duty_b at cycle wr_at, which must only take effect from the following period.
    task automatic run_pattern(input string tag, input int period, input int duty_a,
                               input int duty_b, input logic inv, input int n, input int wr_at);
        int   pos;
        int   d;
        logic p;
        logic w;
        wait_wrap(tag);
        for (int i = 1; i <= n; i++) begin
            pos = (i - 1) % (period + 1);
            d   = (i <= period + 1) ? duty_a : duty_b;
            p   = (pos < d) ^ inv;
            w   = ((i % (period + 1)) == 0);
            exp_q.push_back({14'd0, p, w});
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check_pop(tag, {14'd0, pwm0, wrap0});
            if (wr_at > 0 && i == wr_at) begin
                cs0 = 1'b1; we = 1'b1; adr = 2'd2; dat = duty_b[15:0];
            end else if (wr_at > 0 && i == wr_at + 1) begin
                cs0 = 1'b0; we = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] chain_val;
        int          wraps;
        rst = 1'b1; cs0 = 1'b0; cs1 = 1'b0; we = 1'b0; adr = 2'd0; dat = 16'h0000;
        shift = 1'b0; dsi_in = 1'b0; sync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a count and a shift.
        bus_write(1'b0, 2'd2, 16'h0100);
        bus_write(1'b0, 2'd0, 16'h0001);
        @(negedge clk);
        shift = 1'b1; dsi_in = 1'b1;
        repeat (16) @(negedge clk);
        shift = 1'b0;
        exp_q.push_back(16'h0003);
        check_pop("pre_reset_pwm_dsi", {14'd0, pwm0, dsi_mid});
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(16'h0000);
        check_pop("reset_outputs", {13'd0, pwm0, wrap0, dsi_mid});
        exp_q.push_back(16'h0000);
        check_pop("reset_dat_o", dat_o0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(1'b0, 2'd0, 16'h0000, "reset_ctrl");
        bus_read(1'b0, 2'd1, 16'hFFFF, "reset_period");
        bus_read(1'b0, 2'd2, 16'h0000, "reset_duty");
        bus_read(1'b0, 2'd3, 16'h0000, "reset_cnt");

        // PWM, inverted PWM, shadow duty, full duty.
        bus_write(1'b0, 2'd1, 16'd9);
        bus_write(1'b0, 2'd2, 16'd3);
        bus_write(1'b0, 2'd0, 16'h0001);
        run_pattern("pwm_p9_d3", 9, 3, 3, 1'b0, 20, 0);
        bus_write(1'b0, 2'd0, 16'h0005);
        run_pattern("pwm_inv", 9, 3, 3, 1'b1, 20, 0);
        bus_write(1'b0, 2'd0, 16'h0001);
        run_pattern("shadow_duty", 9, 3, 7, 1'b0, 20, 3);
        bus_read(1'b0, 2'd2, 16'd7, "shadow_duty_read");
        bus_write(1'b0, 2'd2, 16'hFFFF);
        run_pattern("duty_max", 9, 'hFFFF, 'hFFFF, 1'b0, 20, 0);

        // PERIOD=0: wrap every cycle, counter stuck at 0.
        bus_write(1'b0, 2'd0, 16'h0000);
        bus_write(1'b0, 2'd1, 16'd0);
        bus_write(1'b0, 2'd2, 16'd0);
        bus_write(1'b0, 2'd0, 16'h0001);
        run_pattern("period0", 0, 0, 0, 1'b0, 10, 0);
        bus_read(1'b0, 2'd3, 16'h0000, "period0_cnt");

        // Oneshot with sticky WRAP and write-one-to-clear.
        reset_dut();
        bus_write(1'b0, 2'd1, 16'd4);
        bus_write(1'b0, 2'd0, 16'h0003);
        wraps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wrap0) wraps++;
        end
        exp_q.push_back(16'd1);
        check_pop("oneshot_wrap_count", wraps[15:0]);
        bus_read(1'b0, 2'd0, 16'h8002, "oneshot_ctrl");
        bus_read(1'b0, 2'd3, 16'h0000, "oneshot_cnt");
        bus_write(1'b0, 2'd0, 16'h8000);
        bus_read(1'b0, 2'd0, 16'h0000, "w1c_clear");

        // W1C away from a wrap clears; W1C on the wrap edge leaves WRAP set.
        bus_write(1'b0, 2'd0, 16'h0001);
        wait_wrap("w1c_align_a");
        bus_write(1'b0, 2'd0, 16'h8001);
        bus_read(1'b0, 2'd0, 16'h0001, "w1c_off_wrap");
        wait_wrap("w1c_align_b");
        repeat (3) @(negedge clk);
        bus_write(1'b0, 2'd0, 16'h8001);
        bus_read(1'b0, 2'd0, 16'h8001, "w1c_on_wrap");

        // Daisy chain through both tiles, then a common sync.
        reset_dut();
        bus_write(1'b0, 2'd0, 16'h0009);
        bus_write(1'b1, 2'd0, 16'h0009);
        chain_val = {16'hA5C3, 16'h1234};
        for (int i = 31; i >= 0; i--) begin
            @(negedge clk);
            shift  = 1'b1;
            dsi_in = chain_val[i];
        end
        @(negedge clk);
        shift = 1'b0;
        exp_q.push_back(16'h0002);
        check_pop("chain_dsi_out", {14'd0, dsi_o1, dsi_mid});
        sync = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;
        @(negedge clk);
        cs0 = 1'b1; cs1 = 1'b1; adr = 2'd3;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        #1;
        check_pop("sync_cnt_tile0", dat_o0);
        check_pop("sync_cnt_tile1", dat_o1);
        check_pop("sync_no_wrap", {14'd0, wrap1, wrap0});
        cs0 = 1'b0; cs1 = 1'b0;
        bus_read(1'b0, 2'd2, 16'h1234, "chain_duty_near");
        bus_read(1'b1, 2'd2, 16'hA5C3, "chain_duty_far");

        // Deselected tile drives zero for every address.
        reset_dut();
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            cs0 = 1'b0; cs1 = 1'b1; adr = a[1:0];
            exp_q.push_back(16'h0000);
            #1;
            check_pop("cs_low_dat", dat_o0);
        end
        cs1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
